// File: rtl/bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter
//
// Shares one combinational 16-bit binary-to-BCD converter among NREQ (2..4)
// requesters. A requester is granted in IDLE, its operand is registered, the
// converter output is registered one cycle later, and the 5-digit result is
// offered with the requester index over a valid/ready handshake.
//
// Handshake: a result transfers on a rising edge where out_valid and out_ready
// are both high; out_valid stays high and every output holds until then.
// Requesters keep req and their operand stable until they see gnt (a
// combinational, one-cycle, one-hot pulse in the capture cycle).
//
// Build option:
//   BCD_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration with pointer ptr
//                           undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req   [NREQ]    per-requester request
//   bin   [16*NREQ] operands, requester i on bin[16*i+15:16*i]
//   gnt   [NREQ]    one-hot grant (combinational)
//   out_valid/out_ready  result handshake
//   out_id [2]      requester that owns the result
//   BCD_0..BCD_4    result digits, least to most significant
//   dbg_state_o [2] FSM state: 0 = IDLE, 1 = CONV, 2 = DONE
//   dbg_ptr_o   [2] round-robin pointer (0 when fixed priority)
// -----------------------------------------------------------------------------
module bcd_conv_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   bin,
    output logic [NREQ-1:0]      gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_id,
    output logic [3:0]           BCD_0,
    output logic [3:0]           BCD_1,
    output logic [3:0]           BCD_2,
    output logic [3:0]           BCD_3,
    output logic [3:0]           BCD_4,
    output logic [1:0]           dbg_state_o,
    output logic [1:0]           dbg_ptr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] op_q;
    logic [1:0]  id_q;
    logic [1:0]  out_id_q;
    logic [19:0] bcd_q;
    logic [19:0] conv_bcd;

    logic            any_req;
    logic [1:0]      win_id;
    logic [15:0]     win_op;
    logic [NREQ-1:0] win_oh;
    int              arb_start;
    int              arb_idx;

`ifdef BCD_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    int         ptr_nxt;

    assign arb_start = int'(ptr_q);

    // Pointer moves to the slot after the winner, wrapping at NREQ so it
    // never names a requester that does not exist.
    always_comb begin
        ptr_nxt = int'(win_id) + 1;
        if (ptr_nxt >= NREQ) begin
            ptr_nxt = 0;
        end
        ptr_d = 2'(ptr_nxt);
    end

    assign dbg_ptr_o = ptr_q;
`else
    assign arb_start = 0;
    assign dbg_ptr_o = 2'd0;
`endif

    // Scan requesters starting at arb_start; the first one asserting req wins.
    always_comb begin
        any_req = 1'b0;
        win_id  = 2'd0;
        win_op  = 16'd0;
        win_oh  = '0;
        arb_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = arb_start + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!any_req && req[arb_idx]) begin
                any_req         = 1'b1;
                win_id          = 2'(arb_idx);
                win_op          = bin[16*arb_idx +: 16];
                win_oh[arb_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt     = win_oh;
                    state_d = CONV;
                end
            end
            CONV: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 16'd0;
            id_q     <= 2'd0;
            out_id_q <= 2'd0;
            bcd_q    <= 20'd0;
`ifdef BCD_ARB_ROUND_ROBIN_EN
            ptr_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                op_q  <= win_op;
                id_q  <= win_id;
`ifdef BCD_ARB_ROUND_ROBIN_EN
                ptr_q <= ptr_d;
`endif
            end
            if (state_q == CONV) begin
                bcd_q    <= conv_bcd;
                out_id_q <= id_q;
            end
        end
    end

    bin2bcd_16 u_conv (
        .bin_i (op_q),
        .bcd_o (conv_bcd)
    );

    assign out_valid   = (state_q == DONE);
    assign out_id      = out_id_q;
    assign BCD_0       = bcd_q[3:0];
    assign BCD_1       = bcd_q[7:4];
    assign BCD_2       = bcd_q[11:8];
    assign BCD_3       = bcd_q[15:12];
    assign BCD_4       = bcd_q[19:16];
    assign dbg_state_o = state_q;

endmodule

// -----------------------------------------------------------------------------
// bin2bcd_16: combinational double-dabble, 16-bit binary to 5 BCD digits.
//   bin_i [16]  binary operand
//   bcd_o [20]  digits, bcd_o[3:0] least significant
// -----------------------------------------------------------------------------
module bin2bcd_16 (
    input  logic [15:0] bin_i,
    output logic [19:0] bcd_o
);

    // Upper 20 bits accumulate digits, lower 16 bits hold the binary being
    // shifted in. A digit >= 5 gets +3 before each shift so it carries
    // correctly into the next decade after doubling.
    logic [35:0] sh;

    always_comb begin
        sh = {20'd0, bin_i};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 5; d++) begin
                if (sh[16+4*d +: 4] >= 4'd5) begin
                    sh[16+4*d +: 4] = sh[16+4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
        bcd_o = sh[35:16];
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  req;
    logic [63:0] bin;
    logic [3:0]  gnt;
    logic        out_valid, out_ready;
    logic [1:0]  out_id, dbg_state, dbg_ptr;
    logic [3:0]  b0, b1, b2, b3, b4;

    logic [2:0]  req3;
    logic [47:0] bin3;
    logic [2:0]  gnt3;
    logic        out_valid3, out_ready3;
    logic [1:0]  out_id3, dbg_state3, dbg_ptr3;
    logic [3:0]  c0, c1, c2, c3, c4;

    int n_chk  = 0;
    int n_fail = 0;
    int ptr4   = 0;
    int ptr3   = 0;

    bcd_conv_arbiter #(.NREQ(4)) dut (
        .clk(clk), .reset(reset), .req(req), .bin(bin), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .BCD_0(b0), .BCD_1(b1), .BCD_2(b2), .BCD_3(b3), .BCD_4(b4),
        .dbg_state_o(dbg_state), .dbg_ptr_o(dbg_ptr)
    );

    bcd_conv_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .bin(bin3), .gnt(gnt3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_id(out_id3),
        .BCD_0(c0), .BCD_1(c1), .BCD_2(c2), .BCD_3(c3), .BCD_4(c4),
        .dbg_state_o(dbg_state3), .dbg_ptr_o(dbg_ptr3)
    );

    // ---------------- reference model ----------------
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int pick(input logic [3:0] r, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start + k) % n;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int rr_start(input int p);
`ifdef BCD_ARB_ROUND_ROBIN_EN
        return p;
`else
        return 0;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 4-requester instance, entered in IDLE.
    task automatic txn4(input logic [3:0] r, input int hold);
        int          g;
        logic [19:0] exp_bcd;
        req = r;
        #1;
        g = pick(r, rr_start(ptr4), 4);
        check("gnt4", {28'd0, gnt}, 32'd1 << g);
        check("state_idle", {30'd0, dbg_state}, 32'd0);
        exp_bcd = to_bcd(int'(bin[16*g +: 16]));
`ifdef BCD_ARB_ROUND_ROBIN_EN
        ptr4 = (g + 1) % 4;
`endif
        tick();                                   // CONV
        bin[16*g +: 16] = 16'($urandom);          // operand may change after grant
        out_ready = (hold == 0);
        #1;
        check("gnt_conv", {28'd0, gnt}, 32'd0);
        check("valid_conv", {31'd0, out_valid}, 32'd0);
        check("state_conv", {30'd0, dbg_state}, 32'd1);
        tick();                                   // DONE
        check("valid_done", {31'd0, out_valid}, 32'd1);
        check("out_id", {30'd0, out_id}, 32'(g));
        check("digits", {12'd0, b4, b3, b2, b1, b0}, {12'd0, exp_bcd});
        check("gnt_done", {28'd0, gnt}, 32'd0);
`ifdef BCD_ARB_ROUND_ROBIN_EN
        check("ptr", {30'd0, dbg_ptr}, 32'(ptr4));
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_id", {30'd0, out_id}, 32'(g));
            check("hold_digits", {12'd0, b4, b3, b2, b1, b0}, {12'd0, exp_bcd});
            check("hold_gnt", {28'd0, gnt}, 32'd0);
            check("hold_state", {30'd0, dbg_state}, 32'd2);
        end
        out_ready = 1'b1;
        tick();                                   // IDLE
        check("valid_idle", {31'd0, out_valid}, 32'd0);
    endtask

    // Transaction on the 3-requester instance, entered in IDLE.
    task automatic txn3(input logic [2:0] r);
        int          g;
        logic [19:0] exp_bcd;
        req3 = r;
        #1;
        g = pick({1'b0, r}, rr_start(ptr3), 3);
        check("gnt3", {29'd0, gnt3}, 32'd1 << g);
        exp_bcd = to_bcd(int'(bin3[16*g +: 16]));
`ifdef BCD_ARB_ROUND_ROBIN_EN
        ptr3 = (g + 1) % 3;
`endif
        tick();
        check("gnt3_conv", {29'd0, gnt3}, 32'd0);
        tick();
        check("valid3", {31'd0, out_valid3}, 32'd1);
        check("out_id3", {30'd0, out_id3}, 32'(g));
        check("digits3", {12'd0, c4, c3, c2, c1, c0}, {12'd0, exp_bcd});
        check("ptr3_range", {31'd0, (dbg_ptr3 < 2'd3)}, 32'd1);
        check("state3", {30'd0, dbg_state3}, 32'd2);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    int bvals[6] = '{0, 9, 10, 9999, 10000, 65535};

    initial begin
        reset = 1'b1; req = 4'hF; bin = {$urandom, $urandom}; out_ready = 1'b1;
        req3 = 3'b111; bin3 = 48'd0; out_ready3 = 1'b1;
        #1;
        check("rst_gnt_a", {28'd0, gnt}, 32'd0);
        tick();
        check("rst_gnt_b", {28'd0, gnt}, 32'd0);
        check("rst_gnt3", {29'd0, gnt3}, 32'd0);
        tick();
        reset = 1'b0; req = 4'd0; req3 = 3'd0;
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_id", {30'd0, out_id}, 32'd0);
        check("rst_digits", {12'd0, b4, b3, b2, b1, b0}, 32'd0);
        check("rst_ptr", {30'd0, dbg_ptr}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_valid3", {31'd0, out_valid3}, 32'd0);
        check("rst_ptr3", {30'd0, dbg_ptr3}, 32'd0);

        // Single request, max operand.
        bin[15:0] = 16'hFFFF;
        txn4(4'b0001, 0);

        // Boundary operands on rotating single requesters.
        for (int i = 0; i < 6; i++) begin
            bin[16*(i%4) +: 16] = 16'(bvals[i]);
            txn4(4'b0001 << (i % 4), 0);
        end

        // Contention with all requesters held.
        for (int i = 0; i < 4; i++) bin[16*i +: 16] = 16'(1000 * (i + 1) + i);
        for (int i = 0; i < 5; i++) txn4(4'b1111, 0);

        // Backpressure for 5 cycles.
        bin[47:32] = 16'd4321;
        txn4(4'b0100, 5);

        // Reset while in CONV discards the conversion.
        bin[31:16] = 16'd777;
        req = 4'b0010;
        #1;
        check("midrst_gnt", {28'd0, gnt}, 32'd1 << pick(4'b0010, rr_start(ptr4), 4));
        tick();
        reset = 1'b1; req = 4'd0;
        tick();
        reset = 1'b0;
        ptr4 = 0; ptr3 = 0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_digits", {12'd0, b4, b3, b2, b1, b0}, 32'd0);
        check("midrst_id", {30'd0, out_id}, 32'd0);
        check("midrst_ptr", {30'd0, dbg_ptr}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_novalid", {31'd0, out_valid}, 32'd0);
        end

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            bin = {$urandom, $urandom};
            if (r == 4'd0) begin
                req = r;
                #1;
                check("rand_nogrant", {28'd0, gnt}, 32'd0);
                tick();
                check("rand_idle", {31'd0, out_valid}, 32'd0);
            end else begin
                txn4(r, $urandom_range(0, 2));
            end
        end
        req = 4'd0;

        // NREQ = 3 wraparound: park ptr at 2, then hold req = 101.
        bin3 = {16'd222, 16'd111, 16'd50000};
        txn3(3'b010);
        for (int i = 0; i < 4; i++) txn3(3'b101);
        req3 = 3'd0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shares a single combinational 16-bit binary-to-BCD converter (`bin2bcd_16`) among up to four requesters, such as display drivers, counters and ADC readouts. The block arbitrates the requests, registers the winning operand, and registers the 5-digit BCD result. It presents that result with its requester ID over a valid/ready output handshake. It sits between the value-producing blocks and the 7-segment display path.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `NREQ`, default 4: number of requesters, legal range 2..4.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  NREQ  per-requester request; requester holds it and its operand until granted
- `bin`  in  16*NREQ  operands; requester i drives `bin[16*i+15:16*i]`
- `gnt`  out  NREQ  one-hot grant, combinational, high only in the capture cycle
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_id`  out  2  index of requester owning the result
- `BCD_0`..`BCD_4`  out  4 each  result digits, least significant to most significant

## Operation
- FSM states are IDLE, CONV and DONE.
- **IDLE:** if any `req` bit is high, `gnt` selects exactly one requester. At the clock edge the block:
  - captures that operand into `op_q`;
  - captures the requester index into `id_q`;
  - advances to CONV.
- **IDLE with no request:** `gnt` = 0 and the FSM stays in IDLE.
- **CONV:** `op_q` drives the internal `bin2bcd_16` instance. At the clock edge the block registers the five digits, loads `out_id` from `id_q`, and advances to DONE.
- **DONE:** `out_valid` = 1, and all outputs hold stable. When `out_ready` = 1 the block returns to IDLE at the edge; otherwise it stays in DONE.
- `gnt` is 0 in CONV and DONE whatever `req` is. While the block is busy, requests wait and nothing is dropped.
- Only one conversion is in flight at a time; the block does not overlap operations.
- Arbitration uses round-robin or fixed priority, as set in Configuration.
- The round-robin pointer `ptr` (2 bits) starts the search at `ptr` and wraps modulo NREQ. After granting requester i, `ptr` becomes (i+1) mod NREQ.
- A requester that keeps `req` high after its grant is treated as making a new request.
- Digits are pure BCD; each is 0..9. `BCD_4` is 0..6 and its bit 3 is always 0.
- Reset values: state IDLE, `ptr` = 0, `op_q` = 0, `id_q` = 0, `out_valid` = 0, `out_id` = 0, all BCD outputs 0. `gnt` is forced to 0 while `reset` is high.
- Reset during CONV or DONE discards the conversion. No `out_valid` pulse appears for it, and its requester is not re-granted automatically.
- `req` bits at or above NREQ do not exist. An unused `out_id` MSB, when NREQ = 2, reads 0.

## Timing
- Let cycle 0 be an IDLE cycle with a request pending; `gnt` is high in cycle 0.
- Cycle 1 is CONV.
- `out_valid` first goes high in cycle 2.
- Minimum latency from grant to valid is 2 cycles.
- Minimum spacing between grants is 3 cycles, when `out_ready` is held high.
- The combinational path `op_q` → `bin2bcd_16` → digit registers must close in a single cycle.
- Requesters sample `gnt` in the same cycle it is asserted. They may change `req` or `bin` from cycle 1 onward.
- Simultaneous `out_ready` and new `req` in DONE: the block goes to IDLE first, so the grant comes in the following cycle.

## Configuration
- `BCD_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority, where the lowest index wins. `ptr` is not implemented, and under continuous contention requester 0 can starve the others.

## Test plan
- Single request: `req` = 0001, `bin[15:0]` = 0xFFFF → `gnt` = 0001 in cycle 0, `out_valid` in cycle 2, digits `BCD_4`..`BCD_0` = 6,5,5,3,5, `out_id` = 0.
- Boundary values: operands 0, 9, 10, 9999, 10000 and 65535 → digits exactly match decimal 00000, 00009, 00010, 09999, 10000 and 65535.
- Contention: `req` = 1111 held, `out_ready` = 1, distinct operands → round-robin grant order 0,1,2,3,0 every 3 cycles with `out_id` matching. Without the macro, requester 0 is granted every time.
- Backpressure: `out_ready` = 0 for 5 cycles in DONE → `out_valid`, digits and `out_id` stay stable, `gnt` stays 0. Asserting `out_ready` gives IDLE next cycle, then a grant.
- Reset mid-operation: assert `reset` in CONV → next cycle all outputs are 0, state is IDLE and `ptr` is 0, and no `out_valid` pulse appears for the discarded request.
- Wraparound with NREQ = 3: `req` = 101 held → grants alternate 2,0,2,0, and `ptr` never selects a nonexistent index.
